// File: rtl/demux8_scan.sv
// -----------------------------------------------------------------------------
// demux8_scan
//   Scanning 8-channel demultiplexer for the far end of an 8:1 multiplexed
//   link. Drives the 3-bit channel select {U,T,S} into an external 8:1 mux,
//   samples the returned mux output Y once per channel after DWELL cycles,
//   and publishes all eight channels as one registered word Q together with
//   a one-cycle FRAME strobe.
//
//   Parameters:
//     WIDTH  bits per channel (Y is WIDTH wide, Q is 8*WIDTH wide)
//     DWELL  cycles spent on each channel before sampling (1..16)
//
//   Ports:
//     CLK    rising-edge clock
//     MR_N   asynchronous active-low master reset
//     EN     scan enable (level)
//     CLR    synchronous clear/restart (only with DEMUX8_SCAN_CLR_EN)
//     Y      mux output for the currently selected channel
//     S,T,U  registered channel select bits 0,1,2
//     Q      captured frame, channel k in Q[k*WIDTH +: WIDTH]
//     FRAME  one-cycle pulse on the edge Q is updated
//     BUSY   high while a frame scan is in progress
//
//   Build option: define DEMUX8_SCAN_CLR_EN to add the CLR input.
// -----------------------------------------------------------------------------
module demux8_scan #(
    parameter int WIDTH = 1,
    parameter int DWELL = 1
) (
    input  logic               CLK,
    input  logic               MR_N,
    input  logic               EN,
`ifdef DEMUX8_SCAN_CLR_EN
    input  logic               CLR,
`endif
    input  logic [WIDTH-1:0]   Y,
    output logic               S,
    output logic               T,
    output logic               U,
    output logic [8*WIDTH-1:0] Q,
    output logic               FRAME,
    output logic               BUSY
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t               state;
    logic [2:0]           sel;
    logic [CW-1:0]        cnt;
    logic [8*WIDTH-1:0]   shadow;
    logic                 clr;

`ifdef DEMUX8_SCAN_CLR_EN
    assign clr = CLR;
`else
    assign clr = 1'b0;
`endif

    assign S = sel[0];
    assign T = sel[1];
    assign U = sel[2];

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state  <= IDLE;
            sel    <= '0;
            cnt    <= '0;
            shadow <= '0;
            Q      <= '0;
            FRAME  <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            FRAME <= 1'b0;
            if (clr) begin
                // Restart the current frame; state and BUSY are left alone.
                Q      <= '0;
                shadow <= '0;
                sel    <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sel <= '0;
                        cnt <= '0;
                        if (EN) begin
                            state <= SCAN;
                            BUSY  <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (cnt == CNT_LAST) begin
                            shadow[sel*WIDTH +: WIDTH] <= Y;
                            cnt <= '0;
                            sel <= sel + 3'd1;
                            if (sel == 3'd7) begin
                                // Slot 7 bypasses the shadow so Q sees it on this edge.
                                Q     <= {Y, shadow[7*WIDTH-1:0]};
                                FRAME <= 1'b1;
                                if (!EN) begin
                                    state <= IDLE;
                                    BUSY  <= 1'b0;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux8_scan.sv
// -----------------------------------------------------------------------------
// tb_demux8_scan
//   Bench for demux8_scan. Two instances: WIDTH=1/DWELL=1 (id 0) and
//   WIDTH=4/DWELL=3 (id 1), each fed by a behavioural 8:1 mux. A frame-level
//   reference model (position-in-frame arithmetic) is compared every cycle;
//   directed vectors and sequences cover latency, back-to-back frames,
//   mid-frame EN drop and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_demux8_scan;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        mr_n, en0, en1;
    logic [7:0]  d0;
    logic [31:0] d1;

    logic        s0, t0, u0, f0, b0;
    logic [7:0]  q0;
    logic [0:0]  y0;
    logic        s1, t1, u1, f1, b1;
    logic [31:0] q1;
    logic [3:0]  y1;

`ifdef DEMUX8_SCAN_CLR_EN
    logic clr0 = 1'b0;
    logic clr1 = 1'b0;
`endif

    // External 8:1 mux models
    always_comb y0 = d0[{u0, t0, s0}];
    always_comb y1 = d1[{u1, t1, s1}*4 +: 4];

    demux8_scan #(.WIDTH(1), .DWELL(1)) u_w1 (
        .CLK(CLK), .MR_N(mr_n), .EN(en0),
`ifdef DEMUX8_SCAN_CLR_EN
        .CLR(clr0),
`endif
        .Y(y0), .S(s0), .T(t0), .U(u0), .Q(q0), .FRAME(f0), .BUSY(b0)
    );

    demux8_scan #(.WIDTH(4), .DWELL(3)) u_w4 (
        .CLK(CLK), .MR_N(mr_n), .EN(en1),
`ifdef DEMUX8_SCAN_CLR_EN
        .CLR(clr1),
`endif
        .Y(y1), .S(s1), .T(t1), .U(u1), .Q(q1), .FRAME(f1), .BUSY(b1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          md [2] = '{1, 3};
    bit          mbusy [2];
    int          mt [2];            // cycle position within the frame
    bit          mframe [2];
    logic [3:0]  mcol [2][8];
    logic [3:0]  mq [2][8];
    bit          chk_on = 1'b0;

    task automatic mreset(input int id);
        mbusy[id] = 1'b0; mt[id] = 0; mframe[id] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mcol[id][k] = '0; mq[id][k] = '0;
        end
    endtask

    task automatic mstep(input int id, input bit mr, input bit en, input logic [3:0] y);
        int d;
        d = md[id];
        if (!mr) begin
            mreset(id);
            return;
        end
        mframe[id] = 1'b0;
        if (!mbusy[id]) begin
            if (en) begin
                mbusy[id] = 1'b1; mt[id] = 0;
            end
        end else begin
            if (mt[id] % d == d - 1) mcol[id][mt[id] / d] = y;
            if (mt[id] == 8 * d - 1) begin
                for (int k = 0; k < 8; k++) mq[id][k] = mcol[id][k];
                mframe[id] = 1'b1;
                mt[id] = 0;
                mbusy[id] = en;
            end else begin
                mt[id]++;
            end
        end
    endtask

    task automatic mcheck(input int id, input logic [2:0] sel, input logic busy,
                          input logic frame, input logic [31:0] q);
        logic [31:0] eq;
        logic [2:0]  esel;
        eq = '0;
        for (int k = 0; k < 8; k++) begin
            if (id == 0) eq[k] = mq[id][k][0];
            else         eq[k*4 +: 4] = mq[id][k];
        end
        esel = mbusy[id] ? 3'(mt[id] / md[id]) : 3'd0;
        chk($sformatf("model%0d_sel", id), {29'b0, sel}, {29'b0, esel});
        chk($sformatf("model%0d_busy", id), {31'b0, busy}, {31'b0, mbusy[id]});
        chk($sformatf("model%0d_frame", id), {31'b0, frame}, {31'b0, mframe[id]});
        chk($sformatf("model%0d_q", id), q, eq);
    endtask

    // Inputs only change #1 after posedge, so the negedge sees what the next edge sees.
    always @(negedge CLK) begin
        if (chk_on) begin
            if (!mr_n) begin
                mreset(0); mreset(1);
            end
            mcheck(0, {u0, t0, s0}, b0, f0, {24'b0, q0});
            mcheck(1, {u1, t1, s1}, b1, f1, q1);
            mstep(0, mr_n, en0, {3'b0, y0});
            mstep(1, mr_n, en1, y1);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic frm(input int id);
        return (id == 0) ? f0 : f1;
    endfunction
    function automatic logic bsy(input int id);
        return (id == 0) ? b0 : b1;
    endfunction
    function automatic logic [31:0] qv(input int id);
        return (id == 0) ? {24'b0, q0} : q1;
    endfunction
    function automatic logic [2:0] selv(input int id);
        return (id == 0) ? {u0, t0, s0} : {u1, t1, s1};
    endfunction
    task automatic set_en(input int id, input logic v);
        if (id == 0) en0 = v; else en1 = v;
    endtask
    task automatic set_data(input int id, input logic [31:0] v);
        if (id == 0) d0 = v[7:0]; else d1 = v;
    endtask

    // Counts edges until FRAME is seen (0 if none within limit).
    task automatic wait_frame(input int id, input int limit, output int n);
        int c;
        n = 0;
        for (c = 1; c <= limit; c++) begin
            @(posedge CLK); #1;
            if (frm(id)) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic count_frames(input int id, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge CLK); #1;
            if (frm(id)) cnt++;
        end
    endtask

    task automatic wait_sel(input int id, input logic [2:0] v, input string name);
        int c;
        for (c = 0; c < 100; c++) begin
            if (selv(id) == v) break;
            @(posedge CLK); #1;
        end
        if (c == 100) chk(name, {29'b0, selv(id)}, {29'b0, v});
    endtask

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic [31:0] exp_q;
        int          exp_lat;
    } vec_t;

    task automatic run_cont(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
        logic [31:0] dat [3];
        int n;
        dat[0] = a; dat[1] = b; dat[2] = c;
        set_data(id, dat[0]);
        set_en(id, 1'b1);
        @(posedge CLK); #1;
        for (int fr = 0; fr < 3; fr++) begin
            wait_frame(id, 100, n);
            chk($sformatf("cont%0d_period%0d", id, fr), n, 8 * md[id]);
            chk($sformatf("cont%0d_q%0d", id, fr), qv(id), dat[fr]);
            chk($sformatf("cont%0d_busy%0d", id, fr), {31'b0, bsy(id)}, (fr < 2) ? 32'd1 : 32'd0);
            if (fr < 2) begin
                set_data(id, dat[fr+1]);
                if (id == 0) chk($sformatf("cont%0d_wrap%0d", id, fr), {29'b0, selv(id)}, 32'd0);
            end
            if (fr == 1) set_en(id, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs [6];
        int   n;
        int   cnt;

        vecs[0] = '{0, 32'h0000_00A6, 32'h0000_00A6, 8};
        vecs[1] = '{1, 32'h8765_4321, 32'h8765_4321, 24};
        vecs[2] = '{0, 32'h0000_00FF, 32'h0000_00FF, 8};
        vecs[3] = '{0, 32'h0000_005A, 32'h0000_005A, 8};
        vecs[4] = '{1, 32'hFEDC_BA98, 32'hFEDC_BA98, 24};
        vecs[5] = '{0, 32'h0000_0000, 32'h0000_0000, 8};

        mr_n = 1'b0; en0 = 1'b0; en1 = 1'b0; d0 = '0; d1 = '0;
        repeat (2) @(posedge CLK);
        chk_on = 1'b1;

        // Reset held with EN high
        #1; en0 = 1'b1; en1 = 1'b1;
        repeat (4) begin
            @(posedge CLK); #1;
            chk("rst_q0", {24'b0, q0}, 32'd0);
            chk("rst_busy0", {31'b0, b0}, 32'd0);
            chk("rst_q1", q1, 32'd0);
            chk("rst_sel1", {29'b0, u1, t1, s1}, 32'd0);
            chk("rst_frame1", {31'b0, f1}, 32'd0);
        end
        mr_n = 1'b1;
        @(posedge CLK); #1;
        chk("rel_busy0", {31'b0, b0}, 32'd1);
        chk("rel_busy1", {31'b0, b1}, 32'd1);
        en0 = 1'b0; en1 = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        chk("rel_idle0", {31'b0, b0}, 32'd0);
        chk("rel_idle1", {31'b0, b1}, 32'd0);

        // Table-driven single frames with a one-cycle EN pulse
        for (int i = 0; i < 6; i++) begin
            set_data(vecs[i].inst, vecs[i].data);
            set_en(vecs[i].inst, 1'b1);
            @(posedge CLK); #1;
            set_en(vecs[i].inst, 1'b0);
            wait_frame(vecs[i].inst, 100, n);
            chk($sformatf("vec%0d_lat", i), n, vecs[i].exp_lat);
            chk($sformatf("vec%0d_q", i), qv(vecs[i].inst), vecs[i].exp_q);
            chk($sformatf("vec%0d_busy", i), {31'b0, bsy(vecs[i].inst)}, 32'd0);
            count_frames(vecs[i].inst, 2 * vecs[i].exp_lat, cnt);
            chk($sformatf("vec%0d_extra", i), cnt, 32'd0);
        end

        // Back-to-back frames with changing data
        run_cont(0, 32'h3C, 32'hC3, 32'h99);
        run_cont(1, 32'h0F1E_2D3C, 32'hA5A5_5A5A, 32'h1234_5678);
        repeat (30) @(posedge CLK);
        #1;

        // EN dropped after channel 2: frame still completes once
        d1 = 32'hCAFE_BABE;
        en1 = 1'b1;
        @(posedge CLK); #1;
        wait_sel(1, 3'd3, "drop_wait_sel");
        en1 = 1'b0;
        count_frames(1, 40, cnt);
        chk("drop_frames", cnt, 32'd1);
        chk("drop_q", q1, 32'hCAFE_BABE);
        chk("drop_busy", {31'b0, b1}, 32'd0);

        // Reset at channel 5: Q cleared at once, no FRAME
        d1 = 32'h1357_9BDF;
        en1 = 1'b1;
        @(posedge CLK); #1;
        en1 = 1'b0;
        wait_sel(1, 3'd5, "mr_wait_sel");
        mr_n = 1'b0;
        #1;
        chk("mr_q", q1, 32'd0);
        chk("mr_busy", {31'b0, b1}, 32'd0);
        chk("mr_sel", {29'b0, u1, t1, s1}, 32'd0);
        @(posedge CLK); #1;
        mr_n = 1'b1;
        count_frames(1, 40, cnt);
        chk("mr_frames", cnt, 32'd0);
        chk("mr_q_after", q1, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(posedge CLK); #1;
            en0  = ($urandom_range(0, 3) != 0);
            en1  = ($urandom_range(0, 4) != 0);
            d0   = 8'($urandom);
            d1   = $urandom;
            mr_n = ($urandom_range(0, 199) != 0);
        end
        @(posedge CLK); #1;
        mr_n = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (40) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
